// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES block scheduler.
package aes_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    START   = 3'd2,
    ENCRYPT = 3'd3,
    DELIVER = 3'd4
  } sched_state_t;

  localparam int unsigned BLOCK_BYTES  = 16;
  localparam int unsigned SER_COOLDOWN = 18;
  localparam int unsigned COOL_W       = 5;

  typedef logic [127:0] aes_block_t;

endpackage

// File: rtl/aes_byte_packer.sv
// Collects 16 plaintext bytes MSB-first into one AES block; full strobes on the 16th byte.
module aes_byte_packer
  import aes_sched_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       shift_en,
  input  logic [7:0] byte_in,
  output aes_block_t block,
  output logic       full
);

  aes_block_t block_r;
  logic [3:0] byte_cnt_r;

  // shift register and byte counter; counter wraps 15 -> 0 as the block completes
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      block_r    <= '0;
      byte_cnt_r <= 4'd0;
    end else if (shift_en) begin
      block_r    <= {block_r[119:0], byte_in};
      byte_cnt_r <= byte_cnt_r + 4'd1;
    end else begin
      block_r    <= block_r;
      byte_cnt_r <= byte_cnt_r;
    end
  end

  assign block = block_r;
  assign full  = shift_en && (byte_cnt_r == 4'(BLOCK_BYTES - 1));

endmodule

// File: rtl/aes_block_scheduler.sv
// Sequences one AES block: fetch 16 plaintext bytes, run the core, hand the ciphertext to the serializer.
// Defining AES_TIMEOUT_EN adds the ENCRYPT watchdog, the TIMEOUT_CYCLES parameter and a live timeout_err.
module aes_block_scheduler
  import aes_sched_pkg::*;
`ifdef AES_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
)
`endif
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         pt_empty,
  input  logic [7:0]   pt_r_data,
  output logic         pt_r_enable,
  output logic         aes_start,
  output logic [127:0] aes_block,
  input  logic         aes_done,
  input  logic [127:0] aes_result,
  input  logic         ct_empty,
  output logic         ct_complete,
  output logic [127:0] ct_raw_data,
  output logic         busy,
  output logic [15:0]  block_count,
  output logic         timeout_err
);

  sched_state_t      state_r, state_nxt_s;
  logic [COOL_W-1:0] cool_cnt_r;
  logic [15:0]       block_count_r;
  aes_block_t        ct_raw_data_r;
  logic              ct_complete_r;
  logic              shift_en_s, full_s, capture_s, deliver_s, tout_s;

  assign shift_en_s = (state_r == FETCH) && !pt_empty;
  assign capture_s  = (state_r == ENCRYPT) && aes_done;
  assign deliver_s  = (state_r == DELIVER) && ct_empty && (cool_cnt_r == COOL_W'(0));

  aes_byte_packer u_packer (
    .clk      (clk),
    .n_rst    (n_rst),
    .shift_en (shift_en_s),
    .byte_in  (pt_r_data),
    .block    (aes_block),
    .full     (full_s)
  );

`ifdef AES_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_r;
  logic            timeout_err_r;

  // a captured result on the expiry cycle takes priority over the timeout
  assign tout_s = (state_r == ENCRYPT) && !aes_done && (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));

  // watchdog over ENCRYPT cycles and sticky timeout flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt_r      <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      wd_cnt_r      <= (state_r == ENCRYPT) ? wd_cnt_r + WD_W'(1) : '0;
      timeout_err_r <= timeout_err_r | tout_s;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign tout_s      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = pt_empty ? IDLE : FETCH;
      FETCH:   state_nxt_s = full_s ? START : FETCH;
      START:   state_nxt_s = ENCRYPT;
      ENCRYPT: begin
        if (capture_s) begin
          state_nxt_s = DELIVER;
        end else if (tout_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ENCRYPT;
        end
      end
      DELIVER: state_nxt_s = deliver_s ? IDLE : DELIVER;
      default: state_nxt_s = IDLE;
    endcase
  end

  // ciphertext capture, delivery pulse, serializer cooldown and block counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ct_raw_data_r <= '0;
      ct_complete_r <= 1'b0;
      cool_cnt_r    <= '0;
      block_count_r <= 16'd0;
    end else begin
      ct_complete_r <= deliver_s;
      if (capture_s) begin
        ct_raw_data_r <= aes_result;
      end else begin
        ct_raw_data_r <= ct_raw_data_r;
      end
      if (deliver_s) begin
        cool_cnt_r    <= COOL_W'(SER_COOLDOWN);
        block_count_r <= block_count_r + 16'd1;
      end else begin
        cool_cnt_r    <= (cool_cnt_r != COOL_W'(0)) ? cool_cnt_r - COOL_W'(1) : cool_cnt_r;
        block_count_r <= block_count_r;
      end
    end
  end

  assign pt_r_enable = shift_en_s;
  assign aes_start   = (state_r == START);
  assign busy        = (state_r != IDLE);
  assign ct_complete = ct_complete_r;
  assign ct_raw_data = ct_raw_data_r;
  assign block_count = block_count_r;

endmodule
